rv32_alu: RTL and testbench



---
 rtl/rv32_alu.sv | 97 +++++++++
 tb/tb_rv32_alu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu.sv
// rv32_alu: 32-bit integer ALU for the RV32I execute stage.
// Produces the OP/OP-IMM result, address/link sums, and the branch flags
// (zero, and the less-than flag carried on the overflow port). With
// REG_OUT=1 all three outputs are registered with one cycle of latency.
module rv32_alu #(
    parameter bit REG_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_op,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic        overflow
);

    // Operation codes, {funct7[5], funct3}
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    logic [4:0]  w_shamt;
    logic        w_lt_signed;
    logic        w_lt_unsigned;
    logic [31:0] w_result;
    logic        w_zero;
    logic        w_less;

    assign w_shamt       = alu_b[4:0];
    assign w_lt_signed   = $signed(alu_a) < $signed(alu_b);
    assign w_lt_unsigned = alu_a < alu_b;

    // Result mux; every unlisted code falls back to ADD so the output is never X
    always_comb begin
        w_result = alu_a + alu_b;
        case (alu_op)
            OP_ADD:  w_result = alu_a + alu_b;
            OP_SUB:  w_result = alu_a - alu_b;
            OP_SLL:  w_result = alu_a << w_shamt;
            OP_SLT:  w_result = {31'b0, w_lt_signed};
            OP_SLTU: w_result = {31'b0, w_lt_unsigned};
            OP_XOR:  w_result = alu_a ^ alu_b;
            OP_SRL:  w_result = alu_a >> w_shamt;
            OP_SRA:  w_result = $unsigned($signed(alu_a) >>> w_shamt);
            OP_OR:   w_result = alu_a | alu_b;
            OP_AND:  w_result = alu_a & alu_b;
            default: w_result = alu_a + alu_b;
        endcase
    end

    // Branch flags: less-than is independent of the selected result
    always_comb begin
        w_zero = (w_result == '0);
        w_less = (alu_op == OP_SLTU) ? w_lt_unsigned : w_lt_signed;
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [31:0] r_result;
            logic        r_zero;
            logic        r_less;

            // Capture every edge; reset wins over the operands presented at that edge
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_result <= '0;
                    r_zero   <= 1'b0;
                    r_less   <= 1'b0;
                end else begin
                    r_result <= w_result;
                    r_zero   <= w_zero;
                    r_less   <= w_less;
                end
            end

            assign alu_result = r_result;
            assign zero       = r_zero;
            assign overflow   = r_less;
        end else begin : g_comb
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;

            assign alu_result = w_result;
            assign zero       = w_zero;
            assign overflow   = w_less;
        end
    endgenerate

endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: drives a combinational and a registered rv32_alu from the
// same stimulus. Combinational outputs are checked right after each drive;
// registered outputs are checked through a scoreboard queue one edge later.
module tb_rv32_alu;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] c_res, r_res;
    logic        c_z, r_z, c_ov, r_ov;

    int n_tests;
    int n_fail;
    exp_t sb[$];

    rv32_alu #(.REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst(rst), .alu_op(op), .alu_a(a), .alu_b(b),
        .alu_result(c_res), .zero(c_z), .overflow(c_ov)
    );

    rv32_alu #(.REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst(rst), .alu_op(op), .alu_a(a), .alu_b(b),
        .alu_result(r_res), .zero(r_z), .overflow(r_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model, written from the operation table
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   sh;
        sh = int'(y[4:0]);
        case (o)
            4'b1000: e.res = x - y;
            4'b0001: e.res = x << sh;
            4'b0010: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0011: e.res = (x < y) ? 32'd1 : 32'd0;
            4'b0100: e.res = x ^ y;
            4'b0101: e.res = x >> sh;
            4'b1101: begin
                e.res = x >> sh;
                if (x[31]) e.res = e.res | ~(32'hFFFFFFFF >> sh);
            end
            4'b0110: e.res = x | y;
            4'b0111: e.res = x & y;
            default: e.res = x + y;
        endcase
        e.z  = (e.res == 32'd0);
        e.ov = (o == 4'b0011) ? (x < y) : ($signed(x) < $signed(y));
        e.name = "";
        return e;
    endfunction

    // One cycle: check the registered result due now, drive, queue the
    // registered expectation, then check the combinational outputs.
    task automatic step(input string nm, input logic r, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic ez, input logic eov);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({"reg_res ", e.name}, r_res, e.res);
            chk({"reg_z ", e.name}, {31'b0, r_z}, {31'b0, e.z});
            chk({"reg_ov ", e.name}, {31'b0, r_ov}, {31'b0, e.ov});
        end
        rst = r;
        op  = o;
        a   = x;
        b   = y;
        e.name = nm;
        if (r) begin
            e.res = '0;
            e.z   = 1'b0;
            e.ov  = 1'b0;
        end else begin
            e.res = er;
            e.z   = ez;
            e.ov  = eov;
        end
        sb.push_back(e);
        #1;
        chk({"comb_res ", nm}, c_res, er);
        chk({"comb_z ", nm}, {31'b0, c_z}, {31'b0, ez});
        chk({"comb_ov ", nm}, {31'b0, c_ov}, {31'b0, eov});
    endtask

    vec_t vt[$];

    initial begin
        exp_t e;
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        int          k;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        op  = 4'b0000;
        a   = '0;
        b   = '0;

        vt.push_back('{"add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1});
        vt.push_back('{"sub_eq",    4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
        vt.push_back('{"sub_neg",   4'b1000, 32'h00000005, 32'h00000006, 32'hFFFFFFFF, 1'b0, 1'b1});
        vt.push_back('{"slt_min",   4'b0010, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1});
        vt.push_back('{"sltu_min",  4'b0011, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0});
        vt.push_back('{"sll_63",    4'b0001, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1'b1});
        vt.push_back('{"srl_31",    4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b1});
        vt.push_back('{"sra_31",    4'b1101, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b1});
        vt.push_back('{"sra_0",     4'b1101, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b1});
        vt.push_back('{"xor",       4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b1});
        vt.push_back('{"or",        4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b1});
        vt.push_back('{"and",       4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b1});
        vt.push_back('{"undef_f",   4'b1111, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b1});
        vt.push_back('{"undef_9",   4'b1001, 32'h0000000A, 32'h00000014, 32'h0000001E, 1'b0, 1'b1});
        vt.push_back('{"pc_plus4",  4'b0000, 32'h00001000, 32'h00000004, 32'h00001004, 1'b0, 1'b0});
        vt.push_back('{"add_neg8",  4'b0000, 32'h00000100, 32'hFFFFFFF8, 32'h000000F8, 1'b0, 1'b0});
        vt.push_back('{"sub_min",   4'b1000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1});
        vt.push_back('{"sra_pos",   4'b1101, 32'h7FFFFFF0, 32'h00000024, 32'h07FFFFFF, 1'b0, 1'b0});
        vt.push_back('{"sltu_big",  4'b0011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1});
        vt.push_back('{"slt_eq",    4'b0010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});

        // Reset held across an edge, then ADD 2+3 exactly one edge after release
        step("rst_hold",  1'b1, 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
        step("rst_hold2", 1'b1, 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);
        step("add_2_3",   1'b0, 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);

        foreach (vt[i])
            step(vt[i].name, 1'b0, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].z, vt[i].ov);

        for (k = 0; k < 40; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (k % 4 == 0) ? ra : $urandom;
            e  = model(ro, ra, rb);
            step($sformatf("rand%0d", k), 1'b0, ro, ra, rb, e.res, e.z, e.ov);
        end

        // Reset mid-stream while SUB 7-7 is presented: registered zero must be 0
        step("add_pre",   1'b0, 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        step("rst_sub77", 1'b1, 4'b1000, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
        step("post_rst",  1'b0, 4'b1000, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
        step("drain",     1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
